stark_chkpt_pool: RTL and testbench
===================================

// Module: stark_chkpt_pool
// PURPOSE
//  Branch-checkpoint pool for the Stark rename stage. Tracks which
//  checkpoint-RAM slots are free and offers the lowest four free indices.
//  Allocates one slot per branch group, or one per branch.
//  Frees slots on normal branch completion (internal freer) and on
//  misprediction backout (external ports).
//  Instanced by the checkpoint manager.
// PARAMETERS
//  NCHKPT       16   number of checkpoint slots; CW=$clog2(NCHKPT) = checkpt_ndx_t width
//  ROB_ENTRIES  32   ROB size; NGRP=ROB_ENTRIES/4 pipeline groups
//  GROUP_ALLOC  1    1: one slot per alloc request; 0: one slot per set br[] bit
// PORTS
//  clk           in   1        single clock, rising edge
//  rst           in   1        reset, asynchronous, active-low
//  alloc_chkpt   in   1        allocate request, one-cycle pulse
//  br            in   4        per-slot branch mask (used only when GROUP_ALLOC=0)
//  chkptn        out  4xCW     lowest four free indices, ascending; [0] = lowest
//  free_chkpt_i  in   4        normal-free strobes
//  fchkpt_i      in   4xCW     indices for free_chkpt_i
//  free_chkpt2   in   4        backout-free strobes
//  fchkpt2       in   4xCW     indices for free_chkpt2
//  stall         out  1        not enough free slots; an alloc this cycle is ignored
//  pgh           in   NGRPxpipeline_group_hdr_t   group headers (v,has_branch,cndxv,cndx,sn,done)
//  free          out  1        freer: registered free pulse
//  chkpt         out  CW       freer: slot being freed
//  chkpt_gndx    out  6        freer: group index of that slot
// BEHAVIOUR
//  - State: avail[NCHKPT] bit-vector, 1 = free.
//  - Reset (rst low, async): avail = all ones except bit 0. Slot 0 is the boot
//    checkpoint. free=0, chkpt=0, chkpt_gndx=0, freer scan pointer=0, freed[]=0.
//  - chkptn: combinational priority encode of avail, lowest first.
//    Entries beyond the free count read 0.
//  - need = GROUP_ALLOC ? 1 : popcount(br).
//  - stall = (popcount(avail) < (GROUP_ALLOC ? 1 : 4)); combinational.
//  - Alloc (alloc_chkpt & !stall):
//      GROUP_ALLOC=1: clear avail[chkptn[0]] at the next edge.
//      GROUP_ALLOC=0: clear avail[chkptn[i]] for each br[i]=1.
//    New chkptn values are visible one cycle after the pulse.
//  - Free: each strobe k of free_chkpt_i/free_chkpt2 sets avail[index] at the
//    next edge. All 8 strobes are applied in the same cycle.
//    Freeing an already-free slot is a no-op. Duplicate indices are harmless.
//  - Same-cycle alloc and free: allocs use pre-edge chkptn; frees are OR-ed in
//    last, so free wins on any index collision.
//  - Freer: scan pointer g walks 0..NGRP-1, one group per cycle, wrapping at NGRP-1.
//    If pgh[g].v & has_branch & cndxv & done & !freed[g]:
//      next edge free=1, chkpt=pgh[g].cndx, chkpt_gndx=g, freed[g]=1.
//    Otherwise free=0.
//    freed[g] clears whenever pgh[g].v=0.
//    The freer feeds free_chkpt_i[0] internally, OR-ed with external strobe 0.
//  - Slot 0 is freed/allocated like any other slot after reset.
// STRUCTURE
//  - Shared package (Stark_pkg): checkpt_ndx_t, pipeline_group_hdr_t,
//    ROB_ENTRIES, NCHKPT, TRUE/FALSE.
//  - Sub-module stark_chkpt_group_freer: scan pointer, freed[] bitmap,
//    free/chkpt/chkpt_gndx registers.
//  - Top holds avail[], encoder, popcount and stall logic.
// TESTING
//  1. Reset, NCHKPT=16 -> chkptn={1,2,3,4}, stall=0, free=0.
//  2. GROUP_ALLOC=1: pulse alloc 15 times on consecutive cycles
//     -> chkptn[0] steps 1..15; then stall=1; a 16th alloc leaves avail unchanged.
//  3. From full: free_chkpt2[2]=1, fchkpt2[2]=7 -> next cycle stall=0, chkptn[0]=7.
//     Same cycle: alloc + free of index 3 -> 3 ends free.
//  4. GROUP_ALLOC=0, br=4'b1010, alloc after reset -> slots 2,4 busy;
//     chkptn={1,3,5,6}.
//  5. pgh[5]={v,has_branch,cndxv,done,cndx=9}, slot 9 allocated
//     -> within NGRP cycles: one free pulse, chkpt=9, chkpt_gndx=5; avail[9]=1.
//     No repeat until pgh[5].v drops and rises.
//  6. Assert rst mid-alloc, no clk edge -> outputs return to reset values immediately.

Source files
------------

// File: rtl/stark_chkpt_pool_pkg.sv
// Shared Stark rename-stage types and sizing constants used by the checkpoint pool.
package Stark_pkg;

   localparam int unsigned NCHKPT      = 16;
   localparam int unsigned ROB_ENTRIES = 32;
   localparam int unsigned CW          = $clog2(NCHKPT);
   localparam int unsigned NGRP        = ROB_ENTRIES / 4;

   localparam logic TRUE  = 1'b1;
   localparam logic FALSE = 1'b0;

   typedef logic [CW-1:0] checkpt_ndx_t;

   typedef struct packed {
      logic         v;
      logic         has_branch;
      logic         cndxv;
      checkpt_ndx_t cndx;
      logic [7:0]   sn;
      logic         done;
   } pipeline_group_hdr_t;

endpackage

// File: rtl/stark_chkpt_pool_freer.sv
// Walks the pipeline group headers one per cycle and releases the checkpoint of each
// completed branch group exactly once per group occupancy.
module stark_chkpt_group_freer
   import Stark_pkg::*;
#(
   parameter int unsigned NG = NGRP
) (
   input  logic                      clk,
   input  logic                      rst,
   input  pipeline_group_hdr_t [NG-1:0] pgh,
   output logic                      free,
   output checkpt_ndx_t              chkpt,
   output logic [5:0]                chkpt_gndx
);

   localparam int unsigned GW = (NG > 1) ? $clog2(NG) : 1;

   logic [GW-1:0] ptr_q, ptr_d;
   logic [NG-1:0] freed_q, freed_d;
   logic          free_q, free_d;
   checkpt_ndx_t  chkpt_q, chkpt_d;
   logic [5:0]    gndx_q, gndx_d;
   logic          hit;

   always_comb begin
      hit = pgh[ptr_q].v & pgh[ptr_q].has_branch & pgh[ptr_q].cndxv &
            pgh[ptr_q].done & ~freed_q[ptr_q];
      ptr_d = (ptr_q == GW'(NG - 1)) ? '0 : ptr_q + 1'b1;
      // A group slot that goes invalid is re-armed so its next occupant can free again.
      freed_d = freed_q;
      for (int unsigned g = 0; g < NG; g++) begin
         if (!pgh[g].v) freed_d[g] = 1'b0;
      end
      if (hit) freed_d[ptr_q] = 1'b1;
      free_d  = hit;
      chkpt_d = hit ? pgh[ptr_q].cndx : chkpt_q;
      gndx_d  = hit ? 6'(ptr_q) : gndx_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr_q   <= '0;
         freed_q <= '0;
         free_q  <= 1'b0;
         chkpt_q <= '0;
         gndx_q  <= '0;
      end else begin
         ptr_q   <= ptr_d;
         freed_q <= freed_d;
         free_q  <= free_d;
         chkpt_q <= chkpt_d;
         gndx_q  <= gndx_d;
      end
   end

   assign free       = free_q;
   assign chkpt      = chkpt_q;
   assign chkpt_gndx = gndx_q;

endmodule

// File: rtl/stark_chkpt_pool.sv
// Branch-checkpoint pool: free-slot bitmap, lowest-four encoder, stall and alloc/free update.
module stark_chkpt_pool
   import Stark_pkg::*;
#(
   parameter int unsigned NCHKPT      = Stark_pkg::NCHKPT,
   parameter int unsigned ROB_ENTRIES = Stark_pkg::ROB_ENTRIES,
   parameter int unsigned GROUP_ALLOC = 1
) (
   input  logic                                      clk,
   input  logic                                      rst,
   input  logic                                      alloc_chkpt,
   input  logic [3:0]                                br,
   output logic [3:0][$clog2(NCHKPT)-1:0]            chkptn,
   input  logic [3:0]                                free_chkpt_i,
   input  logic [3:0][$clog2(NCHKPT)-1:0]            fchkpt_i,
   input  logic [3:0]                                free_chkpt2,
   input  logic [3:0][$clog2(NCHKPT)-1:0]            fchkpt2,
   output logic                                      stall,
   input  pipeline_group_hdr_t [ROB_ENTRIES/4-1:0]   pgh,
   output logic                                      free,
   output logic [$clog2(NCHKPT)-1:0]                 chkpt,
   output logic [5:0]                                chkpt_gndx
);

   localparam int unsigned LCW = $clog2(NCHKPT);
   localparam logic [NCHKPT-1:0] AVAIL_RST = ~(NCHKPT'(1));

   logic [NCHKPT-1:0] avail_q, avail_d;
   logic [LCW:0]      nfree;
   logic [3:0]        alloc_mask;
   logic              fr_free;
   checkpt_ndx_t      fr_chkpt;

   stark_chkpt_group_freer #(.NG(ROB_ENTRIES / 4)) u_freer (
      .clk        (clk),
      .rst        (rst),
      .pgh        (pgh),
      .free       (fr_free),
      .chkpt      (fr_chkpt),
      .chkpt_gndx (chkpt_gndx)
   );

   assign free  = fr_free;
   assign chkpt = LCW'(fr_chkpt);

   always_comb begin
      chkptn = '0;
      nfree  = '0;
      for (int unsigned s = 0; s < NCHKPT; s++) begin
         if (avail_q[s]) begin
            if (nfree < 4) chkptn[nfree[1:0]] = LCW'(s);
            nfree = nfree + 1'b1;
         end
      end
   end

   assign stall      = (nfree < ((GROUP_ALLOC != 0) ? 1 : 4));
   assign alloc_mask = (GROUP_ALLOC != 0) ? 4'b0001 : br;

   // Allocations consume pre-edge chkptn; frees are applied afterwards so they win collisions.
   always_comb begin
      avail_d = avail_q;
      if (alloc_chkpt && !stall) begin
         for (int unsigned i = 0; i < 4; i++) begin
            if (alloc_mask[i] && ((LCW+1)'(i) < nfree)) avail_d[chkptn[i]] = 1'b0;
         end
      end
      for (int unsigned k = 0; k < 4; k++) begin
         if (free_chkpt_i[k]) avail_d[fchkpt_i[k]] = 1'b1;
         if (free_chkpt2[k])  avail_d[fchkpt2[k]]  = 1'b1;
      end
      if (fr_free) avail_d[LCW'(fr_chkpt)] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) avail_q <= AVAIL_RST;
      else      avail_q <= avail_d;
   end

endmodule

// File: tb/tb_stark_chkpt_pool.sv
// Directed bench for the checkpoint pool: one group-alloc instance and one per-branch instance.
module tb_stark_chkpt_pool;
   import Stark_pkg::*;

   logic clk = 1'b0;
   logic rst;

   logic                           a_alloc, a_stall, a_free;
   logic [3:0]                     a_br, a_fi, a_f2;
   logic [3:0][3:0]                a_chkptn, a_fidx, a_f2idx;
   pipeline_group_hdr_t [NGRP-1:0] a_pgh;
   logic [3:0]                     a_chkpt;
   logic [5:0]                     a_gndx;

   logic                           b_alloc, b_stall, b_free;
   logic [3:0]                     b_br, b_fi, b_f2;
   logic [3:0][3:0]                b_chkptn, b_fidx, b_f2idx;
   pipeline_group_hdr_t [NGRP-1:0] b_pgh;
   logic [3:0]                     b_chkpt;
   logic [5:0]                     b_gndx;

   stark_chkpt_pool #(.GROUP_ALLOC(1)) dut_a (
      .clk(clk), .rst(rst), .alloc_chkpt(a_alloc), .br(a_br), .chkptn(a_chkptn),
      .free_chkpt_i(a_fi), .fchkpt_i(a_fidx), .free_chkpt2(a_f2), .fchkpt2(a_f2idx),
      .stall(a_stall), .pgh(a_pgh), .free(a_free), .chkpt(a_chkpt), .chkpt_gndx(a_gndx)
   );

   stark_chkpt_pool #(.GROUP_ALLOC(0)) dut_b (
      .clk(clk), .rst(rst), .alloc_chkpt(b_alloc), .br(b_br), .chkptn(b_chkptn),
      .free_chkpt_i(b_fi), .fchkpt_i(b_fidx), .free_chkpt2(b_f2), .fchkpt2(b_f2idx),
      .stall(b_stall), .pgh(b_pgh), .free(b_free), .chkpt(b_chkpt), .chkpt_gndx(b_gndx)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      logic [31:0] exp;
   } exp_t;

   exp_t        sb[$];
   int          checks   = 0;
   int          failures = 0;
   logic [15:0] model;
   int          pulses;
   logic [3:0]  got_chkpt;
   logic [5:0]  got_gndx;

   function automatic logic [15:0] enc4(input logic [15:0] av);
      logic [15:0] r = '0;
      int          n = 0;
      for (int s = 0; s < 16; s++) begin
         if (av[s] && n < 4) begin
            r[n*4 +: 4] = 4'(s);
            n++;
         end
      end
      return r;
   endfunction

   task automatic expect_v(input string tag, input logic [31:0] e);
      exp_t x;
      x.tag = tag;
      x.exp = e;
      sb.push_back(x);
   endtask

   task automatic check_v(input logic [31:0] obs);
      exp_t x;
      checks++;
      if (sb.size() == 0) begin
         failures++;
         $error("FAIL scoreboard_empty observed=%0h", obs);
      end else begin
         x = sb.pop_front();
         assert (obs === x.exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", x.tag, obs, x.exp);
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic scan_window();
      pulses = 0;
      for (int c = 0; c < 2 * NGRP; c++) begin
         step();
         if (a_free) begin
            pulses++;
            got_chkpt = a_chkpt;
            got_gndx  = a_gndx;
         end
      end
   endtask

   initial begin
      rst = 1'b0;
      a_alloc = 0; a_br = 0; a_fi = 0; a_f2 = 0; a_fidx = '0; a_f2idx = '0; a_pgh = '0;
      b_alloc = 0; b_br = 0; b_fi = 0; b_f2 = 0; b_fidx = '0; b_f2idx = '0; b_pgh = '0;
      got_chkpt = '0; got_gndx = '0;
      repeat (2) step();
      rst   = 1'b1;
      model = 16'hFFFE;

      expect_v("rst_chkptn", {16'h0, enc4(model)}); check_v({16'h0, a_chkptn});
      expect_v("rst_stall", 32'd0);                 check_v({31'h0, a_stall});
      expect_v("rst_free", 32'd0);                  check_v({31'h0, a_free});
      expect_v("rst_b_chkptn", 32'h4321);           check_v({16'h0, b_chkptn});

      // per-branch allocation
      b_br = 4'b1010; b_alloc = 1'b1;
      expect_v("br_alloc_chkptn", 32'h6531);
      step();
      b_alloc = 1'b0; b_br = 4'b0;
      check_v({16'h0, b_chkptn});

      // group allocation until exhausted
      a_alloc = 1'b1;
      for (int i = 1; i <= 15; i++) begin
         expect_v("alloc_seq_chkptn", {16'h0, enc4(model)});
         check_v({16'h0, a_chkptn});
         step();
         model[i] = 1'b0;
      end
      a_alloc = 1'b0;
      expect_v("full_stall", 32'd1);  check_v({31'h0, a_stall});
      expect_v("full_chkptn", 32'd0); check_v({16'h0, a_chkptn});
      a_alloc = 1'b1;
      step();
      a_alloc = 1'b0;
      expect_v("alloc_when_full", {16'h0, enc4(model)}); check_v({16'h0, a_chkptn});

      a_f2 = 4'b0100; a_f2idx[2] = 4'd7;
      step();
      a_f2 = 4'b0; model[7] = 1'b1;
      expect_v("backout_free_stall", 32'd0);           check_v({31'h0, a_stall});
      expect_v("backout_free_chkptn", {16'h0, enc4(model)}); check_v({16'h0, a_chkptn});

      a_alloc = 1'b1;
      step();
      a_alloc = 1'b0; model[7] = 1'b0;
      a_f2 = 4'b0001; a_f2idx[0] = 4'd3;
      step();
      a_f2 = 4'b0; model[3] = 1'b1;

      // alloc and free of the same index in one cycle
      a_alloc = 1'b1; a_fi = 4'b0100; a_fidx[2] = 4'd3;
      step();
      a_alloc = 1'b0; a_fi = 4'b0;
      expect_v("collision_chkptn", {16'h0, enc4(model)}); check_v({16'h0, a_chkptn});

      a_fi = 4'b0010; a_fidx[1] = 4'd5;
      a_f2 = 4'b1001; a_f2idx[0] = 4'd12; a_f2idx[3] = 4'd5;
      step();
      a_fi = 4'b0; a_f2 = 4'b0; model[5] = 1'b1; model[12] = 1'b1;
      expect_v("multi_free_chkptn", 32'h0C53); check_v({16'h0, a_chkptn});

      a_pgh[5].v = 1'b1; a_pgh[5].has_branch = 1'b1; a_pgh[5].cndxv = 1'b1;
      a_pgh[5].done = 1'b1; a_pgh[5].cndx = 4'd9;
      scan_window();
      model[9] = 1'b1;
      expect_v("freer_pulses", 32'd1);    check_v(32'(pulses));
      expect_v("freer_chkpt", 32'd9);     check_v({28'h0, got_chkpt});
      expect_v("freer_gndx", 32'd5);      check_v({26'h0, got_gndx});
      expect_v("freer_avail", {16'h0, enc4(model)}); check_v({16'h0, a_chkptn});
      scan_window();
      expect_v("freer_no_repeat", 32'd0); check_v(32'(pulses));
      a_pgh[5].v = 1'b0;
      repeat (2) step();
      a_pgh[5].v = 1'b1;
      scan_window();
      expect_v("freer_rearm", 32'd1);     check_v(32'(pulses));

      // asynchronous reset between edges
      a_alloc = 1'b1; b_alloc = 1'b1;
      #2;
      rst = 1'b0;
      #1;
      model = 16'hFFFE;
      expect_v("async_rst_chkptn", {16'h0, enc4(model)}); check_v({16'h0, a_chkptn});
      expect_v("async_rst_stall", 32'd0);   check_v({31'h0, a_stall});
      expect_v("async_rst_free", 32'd0);    check_v({31'h0, a_free});
      expect_v("async_rst_chkpt", 32'd0);   check_v({28'h0, a_chkpt});
      expect_v("async_rst_gndx", 32'd0);    check_v({26'h0, a_gndx});
      expect_v("async_rst_b_chkptn", 32'h4321); check_v({16'h0, b_chkptn});
      a_alloc = 1'b0; b_alloc = 1'b0;
      step();
      rst = 1'b1;
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
